// File: rtl/mem_pkg.sv
// Shared types and small decode helpers for the load/store unit.
package mem_pkg;

    typedef enum logic [3:0] {
        LW  = 4'd0,
        LB  = 4'd1,
        LBU = 4'd2,
        LH  = 4'd3,
        LHU = 4'd4,
        LWL = 4'd5,
        LWR = 4'd6,
        SW  = 4'd7,
        SB  = 4'd8,
        SH  = 4'd9
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mem_state_t;

    // True for operations that write memory.
    function automatic logic is_store(input mem_op_t op);
        case (op)
            SW, SB, SH: is_store = 1'b1;
            default:    is_store = 1'b0;
        endcase
    endfunction

    // Word ops need a 4-byte boundary, halfword ops a 2-byte boundary;
    // LWL/LWR are unaligned by design and bytes are always aligned.
    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] k);
        case (op)
            LW, SW:      is_misaligned = (k != 2'b00);
            LH, LHU, SH: is_misaligned = k[0];
            default:     is_misaligned = 1'b0;
        endcase
    endfunction

    // Little-endian byte lanes touched by the access.
    function automatic logic [3:0] byte_enable(input mem_op_t op, input logic [1:0] k);
        case (op)
            SB:      byte_enable = 4'b0001 << k;
            SH:      byte_enable = k[1] ? 4'b1100 : 4'b0011;
            default: byte_enable = 4'b1111;
        endcase
    endfunction

    // Narrow stores replicate their data into every lane so the slave can
    // pick whichever lane the byte enables select.
    function automatic logic [31:0] store_lanes(input mem_op_t op, input logic [31:0] d);
        case (op)
            SB:      store_lanes = {4{d[7:0]}};
            SH:      store_lanes = {2{d[15:0]}};
            default: store_lanes = d;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load-result formatter: lane extraction, sign/zero extension
// and the LWL/LWR partial-word merge with the old register value.
module load_align
    import mem_pkg::*;
(
    input  mem_op_t     op_i,
    input  logic [1:0]  k_i,
    input  logic [31:0] w_i,
    input  logic [31:0] rt_old_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] lwl_s;
    logic [31:0] lwr_s;

    // Pick the addressed byte and halfword out of the returned word.
    always_comb begin
        byte_s = 8'h00;
        case (k_i)
            2'd0:    byte_s = w_i[7:0];
            2'd1:    byte_s = w_i[15:8];
            2'd2:    byte_s = w_i[23:16];
            2'd3:    byte_s = w_i[31:24];
            default: byte_s = 8'h00;
        endcase
        half_s = k_i[1] ? w_i[31:16] : w_i[15:0];
    end

    // LWL fills the top bytes from memory, LWR the bottom bytes; the rest
    // keeps the old register contents.
    always_comb begin
        lwl_s = w_i;
        lwr_s = w_i;
        case (k_i)
            2'd0: begin
                lwl_s = {w_i[7:0], rt_old_i[23:0]};
                lwr_s = w_i;
            end
            2'd1: begin
                lwl_s = {w_i[15:0], rt_old_i[15:0]};
                lwr_s = {rt_old_i[31:24], w_i[31:8]};
            end
            2'd2: begin
                lwl_s = {w_i[23:0], rt_old_i[7:0]};
                lwr_s = {rt_old_i[31:16], w_i[31:16]};
            end
            2'd3: begin
                lwl_s = w_i;
                lwr_s = {rt_old_i[31:8], w_i[31:24]};
            end
            default: begin
                lwl_s = w_i;
                lwr_s = w_i;
            end
        endcase
    end

    // Final result select by operation.
    always_comb begin
        data_o = 32'h0000_0000;
        case (op_i)
            LW:      data_o = w_i;
            LB:      data_o = {{24{byte_s[7]}}, byte_s};
            LBU:     data_o = {24'h00_0000, byte_s};
            LH:      data_o = {{16{half_s[15]}}, half_s};
            LHU:     data_o = {16'h0000, half_s};
            LWL:     data_o = lwl_s;
            LWR:     data_o = lwr_s;
            default: data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit owning the data-memory port: one request at a time,
// waitrequest-style bus with byte enables, optional stall timeout.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  mem_op_t           op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    input  logic [31:0]       rt_old,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_waitrequest,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic              store_done,
    output logic              addr_err,
    output logic              bus_err
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    mem_state_t        state_q,      state_d;
    mem_op_t           op_q,         op_d;
    logic [1:0]        k_q,          k_d;
    logic [31:0]       rt_old_q,     rt_old_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic              busy_q,       busy_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic              mem_read_q,   mem_read_d;
    logic              mem_write_q,  mem_write_d;
    logic [3:0]        be_q,         be_d;
    logic [31:0]       wdata_q,      wdata_d;
    logic [31:0]       rd_data_q,    rd_data_d;
    logic              rd_valid_q,   rd_valid_d;
    logic              store_done_q, store_done_d;
    logic              addr_err_q,   addr_err_d;
    logic              bus_err_q,    bus_err_d;

    logic [31:0]       aligned_s;
    logic              timeout_hit_s;

    load_align u_load_align (
        .op_i     (op_q),
        .k_i      (k_q),
        .w_i      (mem_readdata),
        .rt_old_i (rt_old_q),
        .data_o   (aligned_s)
    );

    // The current stalled cycle is the TIMEOUT-th one when the count of
    // earlier stalls is TIMEOUT-1; never fires when the timeout is disabled.
    always_comb begin
        if (TIMEOUT != 0) begin
            timeout_hit_s = ((32'(cnt_q) + 32'd1) >= TIMEOUT);
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Next-state and next-output logic for the request FSM.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        k_d          = k_q;
        rt_old_d     = rt_old_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        mem_addr_d   = mem_addr_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        store_done_d = 1'b0;
        addr_err_d   = 1'b0;
        bus_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    op_d     = op;
                    k_d      = addr[1:0];
                    rt_old_d = rt_old;
                    busy_d   = 1'b1;
                    if (is_misaligned(op, addr[1:0])) begin
                        state_d    = RESP;
                        addr_err_d = 1'b1;
                    end else begin
                        state_d     = ACCESS;
                        cnt_d       = '0;
                        mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                        mem_read_d  = !is_store(op);
                        mem_write_d = is_store(op);
                        be_d        = byte_enable(op, addr[1:0]);
                        wdata_d     = store_lanes(op, store_data);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (!mem_waitrequest) begin
                    state_d     = RESP;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (is_store(op_q)) begin
                        store_done_d = 1'b1;
                    end else begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = aligned_s;
                    end
                end else if (timeout_hit_s) begin
                    state_d     = RESP;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    bus_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d     = IDLE;
                busy_d      = 1'b0;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops the strobes immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            op_q         <= LW;
            k_q          <= 2'b00;
            rt_old_q     <= 32'h0000_0000;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            mem_addr_q   <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            be_q         <= 4'b0000;
            wdata_q      <= 32'h0000_0000;
            rd_data_q    <= 32'h0000_0000;
            rd_valid_q   <= 1'b0;
            store_done_q <= 1'b0;
            addr_err_q   <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            k_q          <= k_d;
            rt_old_q     <= rt_old_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            mem_addr_q   <= mem_addr_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            store_done_q <= store_done_d;
            addr_err_q   <= addr_err_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign busy           = busy_q;
    assign mem_address    = mem_addr_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_byteenable = be_q;
    assign mem_writedata  = wdata_q;
    assign rd_data        = rd_data_q;
    assign rd_valid       = rd_valid_q;
    assign store_done     = store_done_q;
    assign addr_err       = addr_err_q;
    assign bus_err        = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios followed by
// randomized operations, checked against a byte-level reference model.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req = 1'b0;
    mem_op_t     op = LW;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic [31:0] rt_old = 32'h0;
    logic        busy;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = 32'h0;
    logic        mem_waitrequest = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        store_done;
    logic        addr_err;
    logic        bus_err;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] model_rd = 32'h0;

    mem_access_unit #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req             (req),
        .op              (op),
        .addr            (addr),
        .store_data      (store_data),
        .rt_old          (rt_old),
        .busy            (busy),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byteenable  (mem_byteenable),
        .mem_writedata   (mem_writedata),
        .mem_readdata    (mem_readdata),
        .mem_waitrequest (mem_waitrequest),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .store_done      (store_done),
        .addr_err        (addr_err),
        .bus_err         (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic ref_misaligned(input mem_op_t o, input logic [31:0] a);
        int unsigned off;
        off = a % 4;
        if (o == LW || o == SW) return (off != 0);
        if (o == LH || o == LHU || o == SH) return ((off % 2) != 0);
        return 1'b0;
    endfunction

    function automatic logic ref_store(input mem_op_t o);
        return (o == SW || o == SB || o == SH);
    endfunction

    function automatic logic [3:0] ref_be(input mem_op_t o, input logic [31:0] a);
        logic [3:0]  be;
        int unsigned off;
        off = a % 4;
        be = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (o == SB)      be[i] = (i == off);
            else if (o == SH) be[i] = ((i / 2) == (off / 2));
            else              be[i] = 1'b1;
        end
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input mem_op_t o, input logic [31:0] sd);
        if (o == SB) return 32'(sd[7:0]) * 32'h0101_0101;
        if (o == SH) return 32'(sd[15:0]) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] ref_load(input mem_op_t o, input logic [31:0] a,
                                             input logic [31:0] w, input logic [31:0] rt);
        logic [7:0] wb [4];
        logic [7:0] rb [4];
        logic [7:0] res [4];
        int         k;
        int         v;
        k = int'(a % 4);
        for (int i = 0; i < 4; i++) begin
            wb[i] = w[8*i +: 8];
            rb[i] = rt[8*i +: 8];
            res[i] = 8'h00;
        end
        case (o)
            LW:  return w;
            LB:  begin v = $signed(wb[k]); return v; end
            LBU: return 32'(wb[k]);
            LH:  begin v = $signed({wb[k+1], wb[k]}); return v; end
            LHU: return 32'({wb[k+1], wb[k]});
            LWL: begin
                for (int i = 0; i < 4; i++) begin
                    if (i >= 3 - k) res[i] = wb[i - (3 - k)];
                    else            res[i] = rb[i];
                end
                return {res[3], res[2], res[1], res[0]};
            end
            LWR: begin
                for (int i = 0; i < 4; i++) begin
                    if (i < 4 - k) res[i] = wb[i + k];
                    else           res[i] = rb[i];
                end
                return {res[3], res[2], res[1], res[0]};
            end
            default: return 32'h0;
        endcase
    endfunction

    // Issue one request from a negedge sampling point and check every cycle
    // until the unit is back in IDLE; returns at that IDLE cycle's negedge.
    task automatic run_op(input string tag, input mem_op_t o, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rt,
                          input logic [31:0] rdata, input int nwait);
        logic        mis;
        logic        st;
        logic        tmo;
        int          last;
        logic [31:0] exp_rd;
        mis = ref_misaligned(o, a);
        st  = ref_store(o);
        tmo = (nwait >= int'(TMO));
        exp_rd = ref_load(o, a, rdata, rt);

        req = 1'b1; op = o; addr = a; store_data = sd; rt_old = rt;
        mem_readdata = $urandom; mem_waitrequest = 1'b0;
        @(posedge clk); #1;
        req = 1'b0; op = mem_op_t'($urandom_range(0, 9));
        addr = $urandom; store_data = $urandom; rt_old = $urandom;

        if (mis) begin
            @(negedge clk);
            check({tag, " pulses"}, {rd_valid, store_done, addr_err, bus_err}, 4'b0010);
            check({tag, " strobes"}, {mem_read, mem_write}, 2'b00);
            check({tag, " rd_data kept"}, rd_data, model_rd);
            check({tag, " busy"}, busy, 1'b1);
            @(negedge clk);
            check({tag, " idle pulses"}, {rd_valid, store_done, addr_err, bus_err, mem_read, mem_write}, 6'b0);
            check({tag, " idle busy"}, busy, 1'b0);
            return;
        end

        last = tmo ? int'(TMO) : nwait + 1;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            check({tag, " busy"}, busy, 1'b1);
            check({tag, " strobes"}, {mem_read, mem_write}, {!st, st});
            check({tag, " address"}, mem_address, a & 32'hFFFF_FFFC);
            check({tag, " be"}, mem_byteenable, ref_be(o, a));
            if (st) check({tag, " wdata"}, mem_writedata, ref_wdata(o, sd));
            check({tag, " no pulse"}, {rd_valid, store_done, addr_err, bus_err}, 4'b0000);
            mem_waitrequest = (c <= nwait);
            mem_readdata = (c <= nwait) ? 32'($urandom) : rdata;
        end

        @(negedge clk);
        mem_waitrequest = 1'b0;
        mem_readdata = $urandom;
        check({tag, " resp strobes"}, {mem_read, mem_write}, 2'b00);
        check({tag, " resp busy"}, busy, 1'b1);
        if (tmo) begin
            check({tag, " pulses"}, {rd_valid, store_done, addr_err, bus_err}, 4'b0001);
        end else if (st) begin
            check({tag, " pulses"}, {rd_valid, store_done, addr_err, bus_err}, 4'b0100);
        end else begin
            check({tag, " pulses"}, {rd_valid, store_done, addr_err, bus_err}, 4'b1000);
            model_rd = exp_rd;
        end
        check({tag, " rd_data"}, rd_data, model_rd);

        @(negedge clk);
        check({tag, " idle pulses"}, {rd_valid, store_done, addr_err, bus_err, mem_read, mem_write}, 6'b0);
        check({tag, " idle busy"}, busy, 1'b0);
    endtask

    initial begin
        mem_op_t     r_op;
        logic [31:0] r_addr;
        int          r_wait;

        // Reset state.
        #12;
        check("reset outs", {busy, mem_read, mem_write, rd_valid, store_done, addr_err, bus_err}, 7'b0);
        check("reset be", mem_byteenable, 4'b0000);
        check("reset addr", mem_address, 32'h0);
        check("reset wdata", mem_writedata, 32'h0);
        check("reset rd_data", rd_data, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed scenarios.
        run_op("lw100", LW, 32'h100, 32'h0, 32'h0, 32'hDEAD_BEEF, 0);
        check("lw100 literal", rd_data, 32'hDEAD_BEEF);
        run_op("lb103", LB, 32'h103, 32'h0, 32'h0, 32'h8011_2233, 0);
        check("lb103 literal", rd_data, 32'hFFFF_FF80);
        run_op("lbu103", LBU, 32'h103, 32'h0, 32'h0, 32'h8011_2233, 0);
        check("lbu103 literal", rd_data, 32'h0000_0080);
        run_op("sh206", SH, 32'h206, 32'h1234_ABCD, 32'h0, 32'h0, 3);
        run_op("lwl301", LWL, 32'h301, 32'h0, 32'hAABB_CCDD, 32'h4433_2211, 0);
        check("lwl301 literal", rd_data, 32'h2211_CCDD);
        run_op("lwr301", LWR, 32'h301, 32'h0, 32'hAABB_CCDD, 32'h4433_2211, 1);
        check("lwr301 literal", rd_data, 32'hAA44_3322);
        run_op("lw102 mis", LW, 32'h102, 32'h0, 32'h0, 32'h0, 0);
        run_op("sb stall", SB, 32'h0000_0A07, 32'h0000_005A, 32'h0, 32'h0, 2);
        run_op("lw timeout", LW, 32'h500, 32'h0, 32'h0, 32'h1111_2222, 10);
        run_op("lw after tmo", LW, 32'h504, 32'h0, 32'h0, 32'h3333_4444, 0);
        run_op("sw timeout", SW, 32'h508, 32'h0BAD_F00D, 32'h0, 32'h0, int'(TMO));
        run_op("lh edge", LH, 32'h602, 32'h0, 32'h0, 32'h8001_7FFF, int'(TMO) - 1);

        // Reset in the middle of a stalled access.
        req = 1'b1; op = LW; addr = 32'h400; mem_waitrequest = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        check("midrst read", mem_read, 1'b1);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("midrst async strobes", {mem_read, mem_write, busy}, 3'b000);
        check("midrst pulses", {rd_valid, store_done, addr_err, bus_err}, 4'b0000);
        model_rd = 32'h0;
        @(negedge clk);
        reset_n = 1'b1;
        mem_waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post rst quiet", {rd_valid, store_done, addr_err, bus_err, mem_read, mem_write, busy}, 7'b0);
        end
        run_op("lw after rst", LW, 32'h404, 32'h0, 32'h0, 32'h5555_6666, 0);

        // Randomized operations.
        for (int n = 0; n < 60; n++) begin
            r_op = mem_op_t'($urandom_range(0, 9));
            r_addr = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                if (r_op == LW || r_op == SW) r_addr[1:0] = 2'b00;
                if (r_op == LH || r_op == LHU || r_op == SH) r_addr[0] = 1'b0;
            end
            r_wait = ($urandom_range(0, 7) == 0) ? int'(TMO) + 1 : int'($urandom_range(0, 2));
            run_op("rand", r_op, r_addr, $urandom, $urandom, $urandom, r_wait);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store execution unit that owns the CPU's data-memory bus port. Accepts one memory request at a time from the control path, drives a waitrequest-style memory bus with byte enables, and returns sign/zero-extended or merged load data to register writeback. Replaces the single-op load/store data selector: adds byte, halfword and unaligned word operations, a stall-tolerant bus handshake, misalignment detection and an optional bus timeout.

## Interface
Parameters:
- ADDR_W, 32, byte-address width on both sides.
- TIMEOUT, 0, maximum consecutive waitrequest cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock; one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  1  start request; sampled only in IDLE.
- op  in  4  operation code, `mem_op_t`.
- addr  in  ADDR_W  effective byte address from the ALU.
- store_data  in  32  rt value for stores.
- rt_old  in  32  current rt value, used for LWL/LWR merges.
- busy  out  1  high from the cycle after an accepted req until the result cycle.
- mem_address  out  ADDR_W  word-aligned address; bits [1:0] are 0.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_byteenable  out  4  active byte lanes, little-endian.
- mem_writedata  out  32  store data, lane-replicated.
- mem_readdata  in  32  read return data.
- mem_waitrequest  in  1  slave stall.
- rd_data  out  32  load result; held until the next load result.
- rd_valid  out  1  one-cycle pulse; rd_data is valid.
- store_done  out  1  one-cycle pulse; the store was accepted by the bus.
- addr_err  out  1  one-cycle pulse; misaligned access, no bus cycle issued.
- bus_err  out  1  one-cycle pulse; timeout abort.

## Operation
- FSM states:
  - IDLE: not busy; a req here is accepted.
  - ACCESS: bus transaction in flight.
  - RESP: result cycle; outputs its pulse, returns to IDLE.
- IDLE, req=1:
  - Register op and addr.
  - If misaligned, go to RESP with addr_err set. Misaligned means LW/SW with addr[1:0]≠0, or LH/LHU/SH with addr[0]=1.
  - Otherwise go to ACCESS.
- req while not in IDLE is ignored; the control path must hold off while busy=1.
- ACCESS:
  - Strobes, address, byteenable and writedata are registered outputs, held constant while mem_waitrequest=1.
  - At a clock edge with mem_waitrequest=0, the transfer completes: strobes drop and the FSM goes to RESP. For loads, mem_readdata is captured at that edge.
- Byte enables:
  - SW and all loads: 1111.
  - SB: 1<<addr[1:0].
  - SH: 0011 if addr[1]=0, else 1100.
- Store data:
  - SB replicates store_data[7:0] into all four lanes.
  - SH replicates store_data[15:0] into both halves.
- Load result, with k=addr[1:0] and w=captured word:
  - LW: w.
  - LB/LBU: byte k, sign/zero-extended.
  - LH/LHU: halfword addr[1], sign/zero-extended.
  - LWL: (w << 8·(3−k)) | (rt_old & low (3−k) bytes mask).
  - LWR: (w >> 8·k) | (rt_old & high k bytes mask).
  - rt_old is sampled at req acceptance.
- Timeout (TIMEOUT>0):
  - A counter increments each ACCESS cycle with mem_waitrequest=1.
  - When it reaches TIMEOUT, drop strobes and go to RESP with bus_err set; no rd_valid/store_done.
  - The counter clears on entry to ACCESS.
- RESP pulses exactly one of: rd_valid, store_done, addr_err, bus_err.

## Timing
- Reset values:
  - FSM IDLE.
  - busy, mem_read, mem_write, rd_valid, store_done, addr_err, bus_err = 0.
  - mem_byteenable, mem_address, mem_writedata, rd_data = 0.
- Zero-wait access:
  - req accepted at edge 0.
  - Strobe high in cycle 1, sampled at edge 1.
  - Result pulse in cycle 2.
  - Latency is 2 cycles; each wait cycle adds 1.
- Misaligned access: addr_err in cycle 1; no strobe ever asserted.
- Back-to-back: a new req may be accepted in the RESP cycle's following IDLE cycle, giving a minimum spacing of 3 cycles.
- Timeout: bus_err in the cycle after the TIMEOUT-th stalled cycle; strobes low in that same cycle.
- Reset mid-access: strobes drop asynchronously, the FSM goes to IDLE, and no pulse is emitted.

## Structure
- Package `mem_pkg`:
  - `mem_op_t` enum: LW, LB, LBU, LH, LHU, LWL, LWR, SW, SB, SH.
  - `mem_state_t` enum: IDLE, ACCESS, RESP.
  - Helper function `is_store(op)`.
- Sub-module `load_align`: purely combinational extraction, extension and LWL/LWR merge from (op, k, w, rt_old). Instantiated once.
- FSM, timeout counter and bus registers live in the top module.

## Test plan
- LW addr=0x100, waitrequest=0, readdata=0xDEADBEEF → mem_address=0x100, be=1111, rd_data=0xDEADBEEF, rd_valid in cycle 2.
- LB addr=0x103 and LBU addr=0x103, readdata=0x80112233 → 0xFFFFFF80 and 0x00000080.
- SH addr=0x206, store_data=0x1234ABCD, waitrequest high 3 cycles → be=1100, writedata=0xABCDABCD held stable throughout, store_done in cycle 5.
- LWL addr=0x301, rt_old=0xAABBCCDD, readdata=0x44332211 → rd_data=0x2211CCDD. LWR at the same address → 0xAA443322.
- LW addr=0x102 → addr_err pulse in cycle 1, mem_read never asserted, rd_data unchanged.
- TIMEOUT=4, waitrequest stuck high → bus_err after 4 stall cycles, strobes low, then a new LW completes normally. Assert reset_n low mid-ACCESS → strobes drop immediately, no pulse.
